// File: rtl/yam430_pkg.sv
// Shared types and constants for the YAM430 instruction sequencer.
// The state enum and the word/byte widths are used by the sequencer and its bus interface.
package yam430_pkg;

  localparam int unsigned YAM430_WORD_W = 16;
  localparam int unsigned YAM430_BYTE_W = 8;

  localparam logic [YAM430_WORD_W-1:0] YAM430_HALT_OPCODE = 16'h0000;

  typedef enum logic [2:0] {
    StIdle,
    StFetchLo,
    StFetchHi,
    StSave,
    StExec,
    StHalt
  } yam430_seq_state_t;

endpackage

// File: rtl/yam430_sequencer_if.sv
// Program-memory side of the sequencer: one-byte req/ack read channel.
// The master modport is the sequencer; the slave modport is the program memory.
interface yam430_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  import yam430_pkg::*;

  logic                     MemReq;
  logic [ADDR_WIDTH-1:0]    MemAddr;
  logic                     MemAck;
  logic [YAM430_BYTE_W-1:0] MemData;

  modport master (
    output MemReq,
    output MemAddr,
    input  MemAck,
    input  MemData
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    output MemAck,
    output MemData
  );

endinterface

// File: rtl/yam430_fetch_pc.sv
// Program counter for instruction fetch: loadable, increment-enabled,
// wraps modulo 2^ADDR_WIDTH, asynchronously reset to RESET_ADDR.
module yam430_fetch_pc #(
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  inc_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] load_val_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [ADDR_WIDTH-1:0] pc_d, pc_q;

  // Load has priority over increment.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/yam430_sequencer.sv
// YAM430 fetch/control sequencer: fetches 16-bit little-endian words as two bytes,
// then pulses save-old-destination and register-write strobes for each instruction.
module yam430_sequencer
  import yam430_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0]   RESET_ADDR  = '0,
  parameter logic [YAM430_WORD_W-1:0] HALT_OPCODE = YAM430_HALT_OPCODE
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Run,
  yam430_sequencer_if.master       mem_io,
  output logic [YAM430_WORD_W-1:0] Opcode,
  output logic                     AluSaveOldDestIn,
  output logic                     RegWrEn,
  output logic                     Halted,
  output logic                     Busy
);

  yam430_seq_state_t state_d, state_q;

  logic [YAM430_BYTE_W-1:0] lo_byte_d, lo_byte_q;
  logic [YAM430_WORD_W-1:0] opcode_d, opcode_q;
  logic [YAM430_WORD_W-1:0] fetched_word;
  logic [ADDR_WIDTH-1:0]    pc;
  logic                     pc_inc;

  yam430_fetch_pc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_ADDR (RESET_ADDR)
  ) u_fetch_pc (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .inc_i      (pc_inc),
    .load_i     (1'b0),
    .load_val_i (RESET_ADDR),
    .pc_o       (pc)
  );

  assign fetched_word = {mem_io.MemData, lo_byte_q};

  // Next-state: acks are only honoured in the two fetch states.
  always_comb begin
    state_d   = state_q;
    lo_byte_d = lo_byte_q;
    opcode_d  = opcode_q;
    pc_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Run) begin
          state_d = StFetchLo;
        end
      end
      StFetchLo: begin
        if (mem_io.MemAck) begin
          lo_byte_d = mem_io.MemData;
          pc_inc    = 1'b1;
          state_d   = StFetchHi;
        end
      end
      StFetchHi: begin
        if (mem_io.MemAck) begin
          opcode_d = fetched_word;
          pc_inc   = 1'b1;
          state_d  = (fetched_word == HALT_OPCODE) ? StHalt : StSave;
        end
      end
      StSave: begin
        state_d = StExec;
      end
      StExec: begin
        state_d = Run ? StFetchLo : StIdle;
      end
      StHalt: begin
        if (!Run) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= StIdle;
      lo_byte_q <= '0;
      opcode_q  <= '0;
    end else begin
      state_q   <= state_d;
      lo_byte_q <= lo_byte_d;
      opcode_q  <= opcode_d;
    end
  end

  // All outputs decode from registered state only.
  always_comb begin
    mem_io.MemReq    = (state_q == StFetchLo) || (state_q == StFetchHi);
    mem_io.MemAddr   = pc;
    Opcode           = opcode_q;
    AluSaveOldDestIn = (state_q == StSave);
    RegWrEn          = (state_q == StExec);
    Halted           = (state_q == StHalt);
    Busy             = (state_q != StIdle) && (state_q != StHalt);
  end

endmodule

// File: tb/tb_yam430_sequencer.sv
// Directed bench for yam430_sequencer: zero-wait, wait-state, run-drop, reset,
// halt-resume and PC wrap scenarios, checked cycle by cycle on the falling edge.
module tb_yam430_sequencer;

  logic        Clk;
  logic        Rst_n;
  logic        Run;
  logic        run2;
  logic        ack_tie;
  int          ack_delay;
  int          wait_cnt;
  int          n_cmp;
  int          n_bad;

  logic [7:0]  mem1 [256];
  logic [7:0]  mem2 [256];

  logic [15:0] op1, op2;
  logic        sv1, wr1, hlt1, bsy1;
  logic        sv2, wr2, hlt2, bsy2;

  yam430_sequencer_if #(.ADDR_WIDTH(8)) bus1 ();
  yam430_sequencer_if #(.ADDR_WIDTH(8)) bus2 ();

  yam430_sequencer #(
    .ADDR_WIDTH  (8),
    .RESET_ADDR  (8'h00),
    .HALT_OPCODE (16'h0000)
  ) dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .Run              (Run),
    .mem_io           (bus1),
    .Opcode           (op1),
    .AluSaveOldDestIn (sv1),
    .RegWrEn          (wr1),
    .Halted           (hlt1),
    .Busy             (bsy1)
  );

  yam430_sequencer #(
    .ADDR_WIDTH  (8),
    .RESET_ADDR  (8'hFF),
    .HALT_OPCODE (16'h0000)
  ) dut_wrap (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .Run              (run2),
    .mem_io           (bus2),
    .Opcode           (op2),
    .AluSaveOldDestIn (sv2),
    .RegWrEn          (wr2),
    .Halted           (hlt2),
    .Busy             (bsy2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory models: combinational read; bus1 ack either tied high or after ack_delay waits.
  assign bus1.MemData = mem1[bus1.MemAddr];
  assign bus1.MemAck  = ack_tie || (bus1.MemReq && (wait_cnt == ack_delay));
  assign bus2.MemData = mem2[bus2.MemAddr];
  assign bus2.MemAck  = 1'b1;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wait_cnt <= 0;
    end else if (bus1.MemReq && !bus1.MemAck) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check every dut output.
  task automatic cyc(input string tag, input logic req, input logic [7:0] addr,
                     input logic [15:0] op, input logic sv, input logic wr,
                     input logic hlt, input logic bsy);
    @(negedge Clk);
    check({tag, ".req"},  bus1.MemReq,  req);
    check({tag, ".addr"}, bus1.MemAddr, addr);
    check({tag, ".op"},   op1,          op);
    check({tag, ".save"}, sv1,          sv);
    check({tag, ".wr"},   wr1,          wr);
    check({tag, ".halt"}, hlt1,         hlt);
    check({tag, ".busy"}, bsy1,         bsy);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    Run       = 1'b0;
    run2      = 1'b0;
    ack_tie   = 1'b1;
    ack_delay = 0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'h00;
      mem2[i] = 8'h00;
    end
    mem1[0] = 8'h34; mem1[1] = 8'h12; mem1[2] = 8'h78; mem1[3] = 8'h56;
    mem1[4] = 8'h00; mem1[5] = 8'h00;
    mem1[6] = 8'hEF; mem1[7] = 8'hBE;
    mem1[8] = 8'h11; mem1[9] = 8'h22;
    mem1[10] = 8'h99; mem1[11] = 8'h88;
    mem2[8'hFF] = 8'hCD; mem2[8'h00] = 8'hAB;
    mem2[8'h01] = 8'h01; mem2[8'h02] = 8'h02;

    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;

    // Reset values.
    repeat (2) @(negedge Clk);
    check("rst.req",   bus1.MemReq,  1'b0);
    check("rst.addr",  bus1.MemAddr, 8'h00);
    check("rst.op",    op1,          16'h0000);
    check("rst.save",  sv1,          1'b0);
    check("rst.wr",    wr1,          1'b0);
    check("rst.halt",  hlt1,         1'b0);
    check("rst.busy",  bsy1,         1'b0);
    check("rst2.addr", bus2.MemAddr, 8'hFF);
    check("rst2.req",  bus2.MemReq,  1'b0);

    // Zero-wait run to halt: 4 cycles per instruction.
    Rst_n = 1'b1;
    Run   = 1'b1;
    cyc("i1_lo",   1, 8'd0, 16'h0000, 0, 0, 0, 1);
    cyc("i1_hi",   1, 8'd1, 16'h0000, 0, 0, 0, 1);
    cyc("i1_save", 0, 8'd2, 16'h1234, 1, 0, 0, 1);
    cyc("i1_exec", 0, 8'd2, 16'h1234, 0, 1, 0, 1);
    cyc("i2_lo",   1, 8'd2, 16'h1234, 0, 0, 0, 1);
    cyc("i2_hi",   1, 8'd3, 16'h1234, 0, 0, 0, 1);
    cyc("i2_save", 0, 8'd4, 16'h5678, 1, 0, 0, 1);
    cyc("i2_exec", 0, 8'd4, 16'h5678, 0, 1, 0, 1);
    cyc("h_lo",    1, 8'd4, 16'h5678, 0, 0, 0, 1);
    cyc("h_hi",    1, 8'd5, 16'h5678, 0, 0, 0, 1);
    cyc("halt",    0, 8'd6, 16'h0000, 0, 0, 1, 0);
    cyc("halt2",   0, 8'd6, 16'h0000, 0, 0, 1, 0);

    // Halt resume with 3 wait cycles per byte: 10 cycles for the instruction.
    Run       = 1'b0;
    ack_tie   = 1'b0;
    ack_delay = 3;
    cyc("idle", 0, 8'd6, 16'h0000, 0, 0, 0, 0);
    Run = 1'b1;
    for (int i = 0; i < 4; i++) cyc("w_lo", 1, 8'd6, 16'h0000, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc("w_hi", 1, 8'd7, 16'h0000, 0, 0, 0, 1);
    cyc("w_save", 0, 8'd8, 16'hBEEF, 1, 0, 0, 1);
    cyc("w_exec", 0, 8'd8, 16'hBEEF, 0, 1, 0, 1);

    // Run drop in FETCH_HI: instruction still completes, then IDLE.
    ack_delay = 1;
    cyc("d_lo0",  1, 8'd8,  16'hBEEF, 0, 0, 0, 1);
    cyc("d_lo1",  1, 8'd8,  16'hBEEF, 0, 0, 0, 1);
    cyc("d_hi0",  1, 8'd9,  16'hBEEF, 0, 0, 0, 1);
    Run = 1'b0;
    cyc("d_hi1",  1, 8'd9,  16'hBEEF, 0, 0, 0, 1);
    cyc("d_save", 0, 8'd10, 16'h2211, 1, 0, 0, 1);
    cyc("d_exec", 0, 8'd10, 16'h2211, 0, 1, 0, 1);
    cyc("d_idle", 0, 8'd10, 16'h2211, 0, 0, 0, 0);
    cyc("d_idl2", 0, 8'd10, 16'h2211, 0, 0, 0, 0);

    // Asynchronous reset in FETCH_LO.
    ack_delay = 3;
    Run       = 1'b1;
    cyc("r_lo", 1, 8'd10, 16'h2211, 0, 0, 0, 1);
    #2 Rst_n = 1'b0;
    #1;
    check("r_async.req",  bus1.MemReq,  1'b0);
    check("r_async.addr", bus1.MemAddr, 8'h00);
    check("r_async.op",   op1,          16'h0000);
    check("r_async.busy", bsy1,         1'b0);
    check("r_async.save", sv1,          1'b0);
    check("r_async.wr",   wr1,          1'b0);
    Run = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    cyc("r_idle0", 0, 8'd0, 16'h0000, 0, 0, 0, 0);
    cyc("r_idle1", 0, 8'd0, 16'h0000, 0, 0, 0, 0);

    // PC wrap on the RESET_ADDR=FF instance.
    run2 = 1'b1;
    @(negedge Clk);
    check("wr_lo.req",   bus2.MemReq,  1'b1);
    check("wr_lo.addr",  bus2.MemAddr, 8'hFF);
    @(negedge Clk);
    check("wr_hi.req",   bus2.MemReq,  1'b1);
    check("wr_hi.addr",  bus2.MemAddr, 8'h00);
    @(negedge Clk);
    check("wr_save.op",  op2,          16'hABCD);
    check("wr_save.sv",  sv2,          1'b1);
    @(negedge Clk);
    check("wr_exec.wr",  wr2,          1'b1);
    check("wr_exec.sv",  sv2,          1'b0);
    @(negedge Clk);
    check("wr_next.req", bus2.MemReq,  1'b1);
    check("wr_next.addr", bus2.MemAddr, 8'h01);
    run2 = 1'b0;
    repeat (4) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
